// File: rtl/cb_cnt_pkg.sv
// Shared constants and helpers for the cb_udn_mod up/down counter family.
// CNT_UP/CNT_DN encode the UP input; clamp_load limits a load value to the bound.
package cb_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/cb_term_detect.sv
// Bound comparison for the up/down counter: at_bound is high when the next
// step in the current direction would cross the count range.
module cb_term_detect
  import cb_cnt_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             UP,
  output logic             at_bound
);

  assign at_bound = (UP == CNT_UP) ? (Q == MAX_VAL) : (Q == '0);

endmodule

// File: rtl/cb_udn_mod.sv
// Cascadable up/down counter, range 0..MAX_VAL, with combinational carry out
// and a registered wrap pulse. Define CB_UDN_SATURATE_EN to hold at the bounds.
module cb_udn_mod
  import cb_cnt_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SD,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             CAI,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             WRAP
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_term;
  logic             at_bound;
  logic             step;

  // While reset is held the carry chain sees a cleared count.
  assign q_term = RST ? '0 : q_q;

  cb_term_detect #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_term (
    .Q        (q_term),
    .UP       (UP),
    .at_bound (at_bound)
  );

  assign step = EN & CAI;
  assign CAO  = step & at_bound;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (SD) begin
      q_d = MAX_VAL;
    end else if (LD) begin
      q_d = WIDTH'(clamp_load(32'(D), 32'(MAX_VAL)));
    end else if (step) begin
      wrap_d = at_bound;
      if (at_bound) begin
`ifndef CB_UDN_SATURATE_EN
        q_d = (UP == CNT_UP) ? '0 : MAX_VAL;
`endif
      end else begin
        q_d = (UP == CNT_UP) ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_cb_udn_mod.sv
// Scoreboard bench for cb_udn_mod: a default 8-bit instance, a 4-bit MAX_VAL=9
// instance and a two-stage 4-bit cascade, driven by directed vectors.
module tb_cb_udn_mod;

`ifdef CB_UDN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       sd;
    logic       ld;
    logic       en;
    logic       cai;
    logic       up;
    logic [7:0] d;
  } ctl_t;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic [1:0] w;
    logic       cao;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t c_a, c_b, c_c;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] q_a;
  logic       cao_a, w_a;
  logic [3:0] q_b;
  logic       cao_b, w_b;
  logic [3:0] q_lo, q_hi;
  logic       cao_lo, cao_hi, w_lo, w_hi;

  cb_udn_mod #(.WIDTH(8)) u_a (
    .CLK(clk), .RST(c_a.rst), .SD(c_a.sd), .LD(c_a.ld), .D(c_a.d),
    .EN(c_a.en), .CAI(c_a.cai), .UP(c_a.up), .Q(q_a), .CAO(cao_a), .WRAP(w_a)
  );

  cb_udn_mod #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
    .CLK(clk), .RST(c_b.rst), .SD(c_b.sd), .LD(c_b.ld), .D(c_b.d[3:0]),
    .EN(c_b.en), .CAI(c_b.cai), .UP(c_b.up), .Q(q_b), .CAO(cao_b), .WRAP(w_b)
  );

  cb_udn_mod #(.WIDTH(4)) u_lo (
    .CLK(clk), .RST(c_c.rst), .SD(c_c.sd), .LD(c_c.ld), .D(c_c.d[3:0]),
    .EN(c_c.en), .CAI(c_c.cai), .UP(c_c.up), .Q(q_lo), .CAO(cao_lo), .WRAP(w_lo)
  );

  cb_udn_mod #(.WIDTH(4)) u_hi (
    .CLK(clk), .RST(c_c.rst), .SD(c_c.sd), .LD(c_c.ld), .D(c_c.d[7:4]),
    .EN(c_c.en), .CAI(cao_lo), .UP(c_c.up), .Q(q_hi), .CAO(cao_hi), .WRAP(w_hi)
  );

  // Monitor: one expected record per cycle, compared just after the edge.
  always @(posedge clk) begin : monitor
    exp_t       e;
    logic [7:0] aq;
    logic [1:0] aw;
    logic       ac;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin aq = q_a;          aw = {1'b0, w_a};  ac = cao_a;  end
        1:       begin aq = {4'h0, q_b};  aw = {1'b0, w_b};  ac = cao_b;  end
        default: begin aq = {q_hi, q_lo}; aw = {w_hi, w_lo}; ac = cao_hi; end
      endcase
      checks++;
      if (aq !== e.q) begin
        errors++;
        $display("FAIL q dut%0d: got %h expected %h", e.id, aq, e.q);
      end
      checks++;
      if (aw !== e.w) begin
        errors++;
        $display("FAIL wrap dut%0d: got %b expected %b", e.id, aw, e.w);
      end
      checks++;
      if (ac !== e.cao) begin
        errors++;
        $display("FAIL cao dut%0d: got %b expected %b", e.id, ac, e.cao);
      end
      $display("txn dut%0d q=%h wrap=%b cao=%b", e.id, aq, aw, ac);
    end
  end

  task automatic drive(input int id, input logic rst, input logic sd, input logic ld,
                       input logic en, input logic cai, input logic up, input logic [7:0] d,
                       input logic [7:0] eq, input logic [1:0] ew, input logic ecao);
    ctl_t c;
    exp_t e;
    @(negedge clk);
    c = '{rst: rst, sd: sd, ld: ld, en: en, cai: cai, up: up, d: d};
    c_a = '0;
    c_b = '0;
    c_c = '0;
    case (id)
      0:       c_a = c;
      1:       c_b = c;
      default: c_c = c;
    endcase
    e = '{id: id, q: eq, w: ew, cao: ecao};
    sb.push_back(e);
  endtask

  initial begin
    c_a = '0;
    c_b = '0;
    c_c = '0;
    repeat (2) @(negedge clk);

    // Default 8-bit instance: reset then down wrap, load, preset, up wrap.
    drive(0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 2'b00, 1'b1);
    drive(0, 0, 0, 0, 1, 1, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 2'b01, SAT);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 2'b00, 1'b0);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h80, 8'h80, 2'b00, 1'b0);
    drive(0, 0, 0, 0, 1, 1, 1, 8'h00, 8'h81, 2'b00, 1'b0);
    drive(0, 0, 1, 0, 1, 1, 1, 8'h00, 8'hFF, 2'b00, 1'b1);
    drive(0, 0, 0, 0, 1, 1, 1, 8'h00, SAT ? 8'hFF : 8'h00, 2'b01, SAT);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00, SAT ? 8'hFF : 8'h00, 2'b00, 1'b0);

    // MAX_VAL=9 instance: ten up steps from zero.
    drive(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 2'b00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 10)
        drive(1, 0, 0, 0, 1, 1, 1, 8'h00, SAT ? 8'd9 : 8'd0, 2'b01, SAT);
      else
        drive(1, 0, 0, 0, 1, 1, 1, 8'h00, 8'(k), 2'b00, k == 9);
    end
    // Clamped load, then three up steps at the bound.
    drive(1, 0, 0, 1, 0, 0, 0, 8'd12, 8'd9, 2'b00, 1'b0);
    drive(1, 0, 0, 0, 1, 1, 1, 8'h00, SAT ? 8'd9 : 8'd0, 2'b01, SAT);
    drive(1, 0, 0, 0, 1, 1, 1, 8'h00, SAT ? 8'd9 : 8'd1, {1'b0, SAT}, SAT);
    drive(1, 0, 0, 0, 1, 1, 1, 8'h00, SAT ? 8'd9 : 8'd2, {1'b0, SAT}, SAT);
    // Priority among RST, SD and LD.
    drive(1, 0, 0, 1, 0, 0, 0, 8'd3, 8'd3, 2'b00, 1'b0);
    drive(1, 0, 1, 1, 0, 0, 0, 8'd12, 8'd9, 2'b00, 1'b0);
    drive(1, 0, 0, 1, 0, 0, 0, 8'd5, 8'd5, 2'b00, 1'b0);
    drive(1, 1, 1, 1, 1, 1, 1, 8'd5, 8'd0, 2'b00, 1'b0);
    drive(1, 0, 0, 1, 0, 0, 0, 8'd5, 8'd5, 2'b00, 1'b0);
    // Enable low holds; then direction flips take effect on the same edge.
    for (int k = 0; k < 5; k++)
      drive(1, 0, 0, 0, 0, 1, 1, 8'h00, 8'd5, 2'b00, 1'b0);
    drive(1, 0, 0, 0, 1, 1, 0, 8'h00, 8'd4, 2'b00, 1'b0);
    drive(1, 0, 0, 0, 1, 1, 1, 8'h00, 8'd5, 2'b00, 1'b0);

`ifndef CB_UDN_SATURATE_EN
    // Two-stage cascade counting down from 0x00.
    drive(2, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 2'b00, 1'b1);
    drive(2, 0, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 2'b11, 1'b0);
    for (int k = 1; k <= 15; k++)
      drive(2, 0, 0, 0, 1, 1, 0, 8'h00, 8'hFF - 8'(k), 2'b00, 1'b0);
    drive(2, 0, 0, 0, 1, 1, 0, 8'h00, 8'hEF, 2'b01, 1'b0);
`endif

    @(negedge clk);
    c_a = '0;
    c_b = '0;
    c_c = '0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
